// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: the mode select and the
// state enums of the BOUNCE and BREATHE pattern FSMs.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        ModeBlink   = 2'd0,
        ModeCount   = 2'd1,
        ModeBounce  = 2'd2,
        ModeBreathe = 2'd3
    } mode_e;

    // Direction the lit LED is currently travelling in BOUNCE.
    typedef enum logic {
        BncLeft  = 1'b0,
        BncRight = 1'b1
    } bounce_e;

    // Direction the duty cycle is ramping in BREATHE.
    typedef enum logic {
        BrUp   = 1'b0,
        BrDown = 1'b1
    } breathe_e;

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler for the LED pattern generator. Produces the pattern
// tick (full wrap), the breathe step (low-bit wrap) and the PWM phase.
module led_prescaler
    import led_pattern_pkg::*;
#(
    parameter int DIV_LOG2     = 21,
    parameter int BREATHE_LOG2 = 13,
    parameter int PWM_BITS     = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_clr,
    output logic [PWM_BITS-1:0] o_phase,
    output logic                o_tick,
    output logic                o_step
);

    logic [DIV_LOG2-1:0] r_p;

    // Prescaler count: clear wins, otherwise advance only while enabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p <= '0;
        end else if (i_clr) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= r_p + {{(DIV_LOG2-1){1'b0}}, 1'b1};
        end
    end

    // A clear in the same cycle swallows any tick or step.
    assign o_tick  = i_en & ~i_clr & (&r_p);
    assign o_step  = i_en & ~i_clr & (&r_p[BREATHE_LOG2-1:0]);
    assign o_phase = r_p[PWM_BITS-1:0];

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: BLINK, COUNT, BOUNCE and BREATHE patterns driven by a
// shared prescaler. Only the active mode's state advances; a mode change or a
// clear reinitialises every pattern.
module led_pattern_gen #(
    parameter int NUM_CH       = 8,
    parameter int DIV_LOG2     = 21,
    parameter int BREATHE_LOG2 = 13,
    parameter int PWM_BITS     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] led,
    output logic              tick
);
    import led_pattern_pkg::*;

    localparam logic [NUM_CH-1:0]   PosInit = NUM_CH'(1);
    localparam logic [NUM_CH-1:0]   CntOne  = NUM_CH'(1);
    localparam logic [PWM_BITS-1:0] DutyOne = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DutyMax = '1;

    logic                w_tick;
    logic                w_step;
    logic [PWM_BITS-1:0] w_phase;
    mode_e               w_mode_in;
    logic                w_reinit;

    mode_e               r_mode_q;
    logic                r_toggle;
    logic                w_toggle_d;
    logic [NUM_CH-1:0]   r_cnt;
    logic [NUM_CH-1:0]   w_cnt_d;
    logic [NUM_CH-1:0]   r_pos;
    logic [NUM_CH-1:0]   w_pos_d;
    bounce_e             r_bnc;
    bounce_e             w_bnc_d;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_duty_d;
    breathe_e            r_br;
    breathe_e            w_br_d;
    logic [NUM_CH-1:0]   r_led;
    logic [NUM_CH-1:0]   w_led_d;
    logic                r_tick;

    led_prescaler #(
        .DIV_LOG2     (DIV_LOG2),
        .BREATHE_LOG2 (BREATHE_LOG2),
        .PWM_BITS     (PWM_BITS)
    ) u_prescaler (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_clr   (clr),
        .o_phase (w_phase),
        .o_tick  (w_tick),
        .o_step  (w_step)
    );

    assign w_mode_in = mode_e'(mode);
    assign w_reinit  = clr | (w_mode_in != r_mode_q);

    // Next pattern state: reinit on clear or mode change, else advance the active mode only.
    always_comb begin
        w_toggle_d = r_toggle;
        w_cnt_d    = r_cnt;
        w_pos_d    = r_pos;
        w_bnc_d    = r_bnc;
        w_duty_d   = r_duty;
        w_br_d     = r_br;
        if (w_reinit) begin
            w_toggle_d = 1'b0;
            w_cnt_d    = '0;
            w_pos_d    = PosInit;
            w_bnc_d    = BncLeft;
            w_duty_d   = '0;
            w_br_d     = BrUp;
        end else begin
            unique case (r_mode_q)
                ModeBlink: begin
                    if (w_tick) begin
                        w_toggle_d = ~r_toggle;
                    end
                end
                ModeCount: begin
                    if (w_tick) begin
                        w_cnt_d = r_cnt + CntOne;
                    end
                end
                ModeBounce: begin
                    if (w_tick) begin
                        if (r_bnc == BncLeft) begin
                            w_pos_d = r_pos << 1;
                            if (w_pos_d[NUM_CH-1]) begin
                                w_bnc_d = BncRight;
                            end
                        end else begin
                            w_pos_d = r_pos >> 1;
                            if (w_pos_d[0]) begin
                                w_bnc_d = BncLeft;
                            end
                        end
                    end
                end
                ModeBreathe: begin
                    if (w_step) begin
                        if (r_br == BrUp) begin
                            w_duty_d = r_duty + DutyOne;
                            if (w_duty_d == DutyMax) begin
                                w_br_d = BrDown;
                            end
                        end else begin
                            w_duty_d = r_duty - DutyOne;
                            if (w_duty_d == '0) begin
                                w_br_d = BrUp;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // LED drive decoded from the registered mode and current pattern state.
    always_comb begin
        w_led_d = '0;
        unique case (r_mode_q)
            ModeBlink:   w_led_d = {NUM_CH{r_toggle}};
            ModeCount:   w_led_d = r_cnt;
            ModeBounce:  w_led_d = r_pos;
            ModeBreathe: w_led_d = {NUM_CH{(w_phase < r_duty)}};
            default:     w_led_d = '0;
        endcase
    end

    // Pattern state registers, including both FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggle <= 1'b0;
            r_cnt    <= '0;
            r_pos    <= PosInit;
            r_bnc    <= BncLeft;
            r_duty   <= '0;
            r_br     <= BrUp;
        end else begin
            r_toggle <= w_toggle_d;
            r_cnt    <= w_cnt_d;
            r_pos    <= w_pos_d;
            r_bnc    <= w_bnc_d;
            r_duty   <= w_duty_d;
            r_br     <= w_br_d;
        end
    end

    // Registered outputs and the mode seen last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= ModeBlink;
            r_led    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_mode_q <= w_mode_in;
            r_led    <= w_led_d;
            r_tick   <= w_tick;
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with NUM_CH=4, DIV_LOG2=3, BREATHE_LOG2=2, PWM_BITS=2.
module tb_led_pattern_gen;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           clr;
    logic [1:0]     mode;
    logic [NCH-1:0] led;
    logic           tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NUM_CH       (NCH),
        .DIV_LOG2     (3),
        .BREATHE_LOG2 (2),
        .PWM_BITS     (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .mode (mode),
        .led  (led),
        .tick (tick)
    );

    // Reference model: prescaler as an integer mod 8, bounce as a bit index
    // with a +1/-1 direction, breathe as an integer duty with a +1/-1 slope.
    int       m_p;
    int       m_modeq;
    int       m_tog;
    int       m_cnt;
    int       m_bi;
    int       m_bdir;
    int       m_duty;
    int       m_ddir;
    logic [3:0] m_led;
    logic       m_tick;

    task automatic m_init();
        m_tog  = 0;
        m_cnt  = 0;
        m_bi   = 0;
        m_bdir = 1;
        m_duty = 0;
        m_ddir = 1;
    endtask

    task automatic m_reset();
        m_p     = 0;
        m_modeq = 0;
        m_init();
        m_led   = 4'h0;
        m_tick  = 1'b0;
    endtask

    function automatic logic [3:0] m_view();
        case (m_modeq)
            0:       return (m_tog != 0) ? 4'hF : 4'h0;
            1:       return 4'(m_cnt);
            2:       return 4'(1 << m_bi);
            default: return ((m_p % 4) < m_duty) ? 4'hF : 4'h0;
        endcase
    endfunction

    task automatic m_clock();
        logic       tk;
        logic       st;
        logic [3:0] nl;
        nl = m_view();
        tk = en && !clr && (m_p == 7);
        st = en && !clr && ((m_p % 4) == 3);
        if (clr) m_p = 0;
        else if (en) m_p = (m_p + 1) % 8;
        if (clr || int'(mode) != m_modeq) begin
            m_init();
        end else if (m_modeq == 0 && tk) begin
            m_tog = 1 - m_tog;
        end else if (m_modeq == 1 && tk) begin
            m_cnt = (m_cnt + 1) % 16;
        end else if (m_modeq == 2 && tk) begin
            m_bi = m_bi + m_bdir;
            if (m_bi == NCH - 1) m_bdir = -1;
            else if (m_bi == 0) m_bdir = 1;
        end else if (m_modeq == 3 && st) begin
            m_duty = m_duty + m_ddir;
            if (m_duty == 3) m_ddir = -1;
            else if (m_duty == 0) m_ddir = 1;
        end
        m_modeq = int'(mode);
        m_led   = nl;
        m_tick  = tk;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic cyc();
        @(posedge clk);
        if (rst) m_reset();
        else m_clock();
        #1;
        chk("led", 32'(led), 32'(m_led));
        chk("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Run until k tick pulses are seen, bounded by a cycle budget.
    task automatic run_ticks(input int k);
        int seen;
        seen = 0;
        for (int i = 0; i < k * 8 + 16 && seen < k; i++) begin
            cyc();
            if (tick === 1'b1) seen++;
        end
        chk("tick_budget", 32'(seen), 32'(k));
    endtask

    initial begin
        int exp_bnc [7] = '{2, 4, 8, 4, 2, 1, 2};
        int ones;
        int n;
        logic [3:0] held;

        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        mode = 2'd0;
        m_reset();
        #1;
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_tick", 32'(tick), 32'h0);
        run(2);
        rst = 1'b0;
        en  = 1'b1;

        // BLINK: first tick after 8 enabled edges, led follows one cycle later.
        run(7);
        chk("blink_pre_led", 32'(led), 32'h0);
        chk("blink_pre_tick", 32'(tick), 32'h0);
        run(1);
        chk("blink_tick1", 32'(tick), 32'h1);
        chk("blink_led_lag", 32'(led), 32'h0);
        run(1);
        chk("blink_led_on", 32'(led), 32'hF);
        chk("blink_tick_pulse", 32'(tick), 32'h0);
        run(7);
        chk("blink_tick2", 32'(tick), 32'h1);
        run(1);
        chk("blink_led_off", 32'(led), 32'h0);

        // COUNT: 5 ticks then wrap after 16.
        mode = 2'd1;
        run(2);
        run_ticks(5);
        run(1);
        chk("count_5", 32'(led), 32'h5);
        run_ticks(11);
        run(1);
        chk("count_wrap", 32'(led), 32'h0);

        // BOUNCE: 1 then 2,4,8,4,2,1,2 on successive ticks.
        mode = 2'd2;
        run(2);
        chk("bounce_init", 32'(led), 32'h1);
        for (int i = 0; i < 7; i++) begin
            run_ticks(1);
            run(1);
            chk($sformatf("bounce_%0d", i), 32'(led), 32'(exp_bnc[i]));
        end

        // Asynchronous reset mid-BOUNCE at led=4.
        run_ticks(1);
        run(1);
        chk("bounce_pre_rst", 32'(led), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        m_reset();
        run(2);
        rst = 1'b0;
        run_ticks(1);
        run(1);
        chk("bounce_after_rst", 32'(led), 32'h2);

        // BREATHE: duty ramps 1,2,3,2,1,0 so led is on 9 of every 24 cycles.
        mode = 2'd3;
        run(4);
        ones = 0;
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (led === 4'hF) ones++;
            else if (led !== 4'h0) chk("breathe_uniform", 32'(led), 32'h0);
        end
        chk("breathe_ones", 32'(ones), 32'd9);

        // Clear coinciding with a tick: no tick, no advance, next tick 8 cycles on.
        mode = 2'd1;
        run(2);
        run_ticks(2);
        for (int i = 0; i < 8 && m_p != 7; i++) cyc();
        held = led;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_tick", 32'(tick), 32'h0);
        n = 0;
        for (int i = 0; i < 16 && tick !== 1'b1; i++) begin
            cyc();
            n++;
        end
        chk("clr_next_tick", 32'(n), 32'd8);
        chk("clr_no_advance", 32'(led), 32'h0);
        run(1);
        chk("clr_then_count", 32'(led), 32'h1);
        held = led;

        // Enable low: everything frozen.
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("freeze_led", 32'(led), 32'(held));
            chk("freeze_tick", 32'(tick), 32'h0);
        end
        en = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            cyc();
        end
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: LED channel count; legal range 2..32.
REQ-002 SHALL have parameter DIV_LOG2, default 21: pattern tick period is 2^DIV_LOG2 enabled cycles.
REQ-003 SHALL have parameter BREATHE_LOG2, default 13: breathe duty step period is 2^BREATHE_LOG2 enabled cycles.
REQ-004 SHALL have parameter PWM_BITS, default 8: breathe PWM resolution; legal only when PWM_BITS <= BREATHE_LOG2 <= DIV_LOG2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1 bit: advances the prescaler and patterns when 1, freezes them when 0.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear of the prescaler and pattern state.
REQ-009 SHALL have port mode, input, 2 bits: 0 BLINK, 1 COUNT, 2 BOUNCE, 3 BREATHE.
REQ-010 SHALL have port led, output, NUM_CH bits: registered LED drive.
REQ-011 SHALL have port tick, output, 1 bit: registered one-cycle pulse in the cycle after each pattern tick.

Function
REQ-012 Prescaler p (DIV_LOG2 bits) SHALL increment by 1 per cycle while en=1 and wrap modulo 2^DIV_LOG2.
REQ-013 Pattern tick SHALL occur when en=1 and p is all ones; breathe step SHALL occur when en=1 and p[BREATHE_LOG2-1:0] is all ones.
REQ-014 BLINK: toggle bit SHALL invert on each tick; led SHALL be all bits equal to the toggle bit.
REQ-015 COUNT: cnt (NUM_CH bits) SHALL increment by 1 on each tick and wrap from all ones to 0; led SHALL equal cnt.
REQ-016 BOUNCE: FSM states LEFT and RIGHT with one-hot pos; on a tick in LEFT, pos SHALL shift left and the FSM SHALL enter RIGHT when pos reaches the MSB; on a tick in RIGHT, pos SHALL shift right and the FSM SHALL enter LEFT when pos reaches bit 0; led SHALL equal pos.
REQ-017 BREATHE: FSM states UP and DOWN over duty (PWM_BITS bits); on each step, UP SHALL increment duty and enter DOWN at the maximum value; DOWN SHALL decrement duty and enter UP at 0; each led bit SHALL be 1 iff p[PWM_BITS-1:0] < duty.
REQ-018 led SHALL be registered from the current pattern state, so a state change is visible one cycle after the tick edge.
REQ-019 Only the pattern state of the active mode SHALL advance.
REQ-020 When mode differs from registered mode_q, pattern state SHALL reinitialise (toggle=0, cnt=0, pos=1, LEFT, duty=0, UP) without advancing that cycle; p SHALL continue counting.
REQ-021 clr=1 SHALL set p=0 and reinitialise the pattern state, overriding a simultaneous tick or step, and SHALL suppress tick.
REQ-022 While en=0, p, the pattern state, and led SHALL hold, and tick SHALL be 0.

Reset
REQ-023 rst=1 SHALL immediately set p=0, mode_q=0, led=0, tick=0, and the pattern state to its reinitialised values, independent of clk.
REQ-024 Release of rst SHALL resume normal operation at the next clk edge.

Structure
REQ-025 Mode encodings and the BOUNCE and BREATHE state enums SHALL reside in package led_pattern_pkg.
REQ-026 The prescaler, together with tick and step generation, SHALL be a sub-module named led_prescaler; the pattern FSMs SHALL remain in led_pattern_gen.

Verification
All scenarios use NUM_CH=4, DIV_LOG2=3, BREATHE_LOG2=2, PWM_BITS=2.
REQ-027 Assert rst, release, en=1, mode=0 -> led=4'h0 until the first tick at cycle 8; led=4'hF one cycle later; tick pulses every 8 cycles.
REQ-028 mode=1 for 5 ticks -> led=4'h5; after 16 ticks -> led=4'h0 (wrap).
REQ-029 mode=2 -> led sequence on successive ticks is 1,2,4,8,4,2,1,2.
REQ-030 mode=3 -> duty sequence on successive steps is 1,2,3,2,1,0,1; with duty=2, led=4'hF for 2 of every 4 cycles.
REQ-031 clr asserted in the same cycle as a tick -> p=0, no pattern advance, tick=0; en=0 for 20 cycles -> led and tick frozen.
REQ-032 rst asserted mid-BOUNCE with led=4'h4 -> led=4'h0 with no clk edge; after release -> next tick gives led=4'h2 (pos 1 shifted to 2).
